vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Upstream timing stage for the pong graphics path. Generates 640x480@60 Hz VGA timing from the system clock: a pixel-rate enable, horizontal/vertical counters, active-low sync pulses and video_on. pix_x, pix_y and video_on feed the graphics/animation stage directly; hsync_n and vsync_n go to the board pins.

Parameters:
CLK_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); legal range 1..16
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
p_tick  out  1  pixel enable, one clk wide, every CLK_DIV clks
pix_x  out  10  horizontal count 0..H_TOTAL-1
pix_y  out  10  vertical count 0..V_TOTAL-1
video_on  out  1  high when pix_x<H_DISPLAY and pix_y<V_DISPLAY
hsync_n  out  1  horizontal sync, active low
vsync_n  out  1  vertical sync, active low
line_tick  out  1  one clk pulse on the last pixel of each line
frame_tick  out  1  one clk pulse on the last pixel of each frame

Behaviour:
- Reset is clk, asynchronous, active-high; rst: reset rst, asynchronous, active-high; clock clk.
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
- Reset values: div_cnt=0, pix_x=0, pix_y=0, hsync_n=1, vsync_n=1. Derived outputs follow: p_tick=(CLK_DIV==1), video_on=1, line_tick=0, frame_tick=0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. p_tick = (div_cnt==CLK_DIV-1), combinational. With CLK_DIV=1, p_tick is constantly 1.
- Counters advance only on clk edges where p_tick=1.
  - pix_x==H_TOTAL-1 -> pix_x=0 and pix_y increments.
  - pix_x==H_TOTAL-1 and pix_y==V_TOTAL-1 -> both wrap to 0.
  - No other wrap points.
- hsync_n and vsync_n are registered from next-state counter values, so they are cycle-aligned with pix_x/pix_y (zero skew).
  - hsync_n=0 exactly while H_DISPLAY+H_FP <= pix_x <= H_DISPLAY+H_FP+H_SYNC-1 (656..751).
  - vsync_n=0 exactly while V_DISPLAY+V_FP <= pix_y <= V_DISPLAY+V_FP+V_SYNC-1 (490..491).
- video_on is combinational from the registered counters.
- line_tick = p_tick & (pix_x==H_TOTAL-1).
- frame_tick = line_tick & (pix_y==V_TOTAL-1).
- Each tick is exactly one clk wide, even when CLK_DIV>1.
- Reset asserted mid-frame: all state returns to reset values immediately. After release, timing restarts at (0,0) with a full div period before the first advance.
- Counter width is fixed at 10 bits; H_TOTAL and V_TOTAL must be <=1024, checked by an elaboration-time assertion.

Optional Feature:
VGA_SYNC_RGB_REG_EN
- Defined: adds ports rgb_in (in, 3) and rgb_out (out, 3).
  - rgb_out is registered and reset to 0.
  - On each p_tick edge, rgb_out <= video_on ? rgb_in : 3'b000.
  - hsync_n and vsync_n gain one extra pixel-period register stage, keeping rgb and sync aligned at the pins.
- Undefined: those ports are absent and sync outputs have the base timing above.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants (H_*/V_*)
  - derived H_TOTAL/V_TOTAL
  - coordinate width localparam (10)
  - RGB width (3), shared with the graphics stage
- One natural sub-module, pix_tick_div: mod-CLK_DIV counter producing p_tick.

Test Plan:
- CLK_DIV=2, release rst -> p_tick high on clk 2, 4, 6, …; pix_x goes 0->1 on the first p_tick edge.
- Run to pix_x=799, pix_y=0, p_tick=1 -> line_tick=1 for one clk; next state pix_x=0, pix_y=1.
- Scan line 0 -> hsync_n low for exactly 96 pixels, pix_x 656..751; video_on falls at pix_x=640.
- Full frame -> vsync_n low for pix_y 490..491 only; frame_tick pulses once per 840000 clks at (799,524); counters then return to (0,0).
- Assert rst at pix_x=300, pix_y=200 for 3 clks -> outputs at reset values during rst; counting resumes from (0,0) after release.
- VGA_SYNC_RGB_REG_EN defined, rgb_in=3'b110:
  - rgb_out=110 one pixel after a visible pix_x.
  - rgb_out=000 one pixel after pix_x=640.
  - hsync_n falls one pixel later than in the base build.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the pong video path.
//   Default 640x480@60 timing (H_*/V_*), derived totals, the coordinate
//   width used for pix_x/pix_y, and the RGB width shared with the graphics
//   stage. in_win() is a small helper for inclusive window decodes.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 3;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // True when lo <= v <= hi.
  function automatic logic in_win(logic [COORD_W-1:0] v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pix_tick_div.sv
// pix_tick_div: mod-CLK_DIV counter that produces the pixel-rate enable.
//   clk, rst (async, active-high) in; p_tick out, high for one clk when the
//   counter sits on its last value. With CLK_DIV=1 the counter never leaves
//   zero and p_tick is constantly high.
module pix_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  assign p_tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (640x480@60 by default).
//   clk, rst (async, active-high)
//   p_tick      pixel enable, one clk wide every CLK_DIV clks
//   pix_x/pix_y current pixel coordinates (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   video_on    inside the visible window
//   hsync_n/vsync_n active-low sync pulses, registered
//   line_tick/frame_tick one-clk pulses on the last pixel of a line/frame
// Optional build macro VGA_SYNC_RGB_REG_EN adds rgb_in/rgb_out: the colour
// is registered once per pixel, and the syncs get a matching pixel-period
// delay so colour and sync stay aligned at the pins.
module vga_sync_gen import vga_pkg::*; #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               video_on,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               line_tick,
  output logic               frame_tick
`ifdef VGA_SYNC_RGB_REG_EN
  ,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [RGB_W-1:0]   rgb_out
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_DISPLAY + H_FP;
  localparam int HS_HI   = HS_LO + H_SYNC - 1;
  localparam int VS_LO   = V_DISPLAY + V_FP;
  localparam int VS_HI   = VS_LO + V_SYNC - 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);

  // Counters are fixed at 10 bits; reject timings that cannot fit.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL/V_TOTAL must be <= 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .p_tick (p_tick)
  );

  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               hs_base, vs_base;

  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (p_tick) begin
      if (pix_x == H_LAST) begin
        x_nxt = '0;
        y_nxt = (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
      end else begin
        x_nxt = pix_x + 1'b1;
      end
    end
  end

  // Syncs decode the next-state counters so the registered pulse lines up
  // with the registered coordinates on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_x   <= '0;
      pix_y   <= '0;
      hs_base <= 1'b1;
      vs_base <= 1'b1;
    end else begin
      pix_x   <= x_nxt;
      pix_y   <= y_nxt;
      hs_base <= ~in_win(x_nxt, HS_LO, HS_HI);
      vs_base <= ~in_win(y_nxt, VS_LO, VS_HI);
    end
  end

  assign video_on   = (pix_x < H_VIS) && (pix_y < V_VIS);
  assign line_tick  = p_tick & (pix_x == H_LAST);
  assign frame_tick = line_tick & (pix_y == V_LAST);

`ifdef VGA_SYNC_RGB_REG_EN
  // Colour for pixel N appears while pixel N+1 is addressed; the syncs are
  // delayed by the same pixel period so the pins stay consistent.
  logic hs_d, vs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d    <= 1'b1;
      vs_d    <= 1'b1;
      rgb_out <= '0;
    end else if (p_tick) begin
      hs_d    <= hs_base;
      vs_d    <= vs_base;
      rgb_out <= video_on ? rgb_in : '0;
    end
  end

  assign hsync_n = hs_d;
  assign vsync_n = vs_d;
`else
  assign hsync_n = hs_base;
  assign vsync_n = vs_base;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance checked against a
// hand-computed vector table over the first line, plus two tiny-timing
// instances (CLK_DIV=3 and CLK_DIV=1) checked cycle by cycle across two
// full frames, and a mid-line asynchronous reset.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_RGB_REG_EN
  localparam bit RGB_BUILD = 1'b1;
`else
  localparam bit RGB_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       lt;
    logic       ft;
    logic [2:0] rgb;
  } obs_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       p0, v0, h0, vs0, lt0, ft0;
  logic [9:0] x0, y0;
  logic       p3, v3, h3, vs3, lt3, ft3;
  logic [9:0] x3, y3;
  logic       p1, v1, h1, vs1, lt1, ft1;
  logic [9:0] x1, y1;
  obs_t       o0, o3, o1;

`ifdef VGA_SYNC_RGB_REG_EN
  logic [2:0] rgb_in = 3'b110;
  logic [2:0] r0, r3, r1;
  assign o0 = '{p0, x0, y0, h0, vs0, v0, lt0, ft0, r0};
  assign o3 = '{p3, x3, y3, h3, vs3, v3, lt3, ft3, r3};
  assign o1 = '{p1, x1, y1, h1, vs1, v1, lt1, ft1, r1};
`else
  assign o0 = '{p0, x0, y0, h0, vs0, v0, lt0, ft0, 3'b000};
  assign o3 = '{p3, x3, y3, h3, vs3, v3, lt3, ft3, 3'b000};
  assign o1 = '{p1, x1, y1, h1, vs1, v1, lt1, ft1, 3'b000};
`endif

  vga_sync_gen dut (
    .clk(clk), .rst(rst), .p_tick(p0), .pix_x(x0), .pix_y(y0),
    .video_on(v0), .hsync_n(h0), .vsync_n(vs0),
    .line_tick(lt0), .frame_tick(ft0)
`ifdef VGA_SYNC_RGB_REG_EN
    , .rgb_in(rgb_in), .rgb_out(r0)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISPLAY(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut3 (
    .clk(clk), .rst(rst), .p_tick(p3), .pix_x(x3), .pix_y(y3),
    .video_on(v3), .hsync_n(h3), .vsync_n(vs3),
    .line_tick(lt3), .frame_tick(ft3)
`ifdef VGA_SYNC_RGB_REG_EN
    , .rgb_in(rgb_in), .rgb_out(r3)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_DISPLAY(3), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut1 (
    .clk(clk), .rst(rst), .p_tick(p1), .pix_x(x1), .pix_y(y1),
    .video_on(v1), .hsync_n(h1), .vsync_n(vs1),
    .line_tick(lt1), .frame_tick(ft1)
`ifdef VGA_SYNC_RGB_REG_EN
    , .rgb_in(rgb_in), .rgb_out(r1)
`endif
  );

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  vec_t tbl[$];

  task automatic check(string name, obs_t got, obs_t exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    else
      n_pass++;
  endtask

  // Table row: state k clks after reset release (sampled mid-cycle).
  // hs = base-build hsync_n, hsr = hsync_n with the RGB register stage.
  task automatic add(int k, logic p, int x, int y, logic hs, logic hsr,
                     logic von, logic lt, logic [2:0] rgb);
    vec_t v;
    v.k     = k;
    v.e.p   = p;
    v.e.x   = 10'(x);
    v.e.y   = 10'(y);
    v.e.hs  = RGB_BUILD ? hsr : hs;
    v.e.vs  = 1'b1;
    v.e.von = von;
    v.e.lt  = lt;
    v.e.ft  = 1'b0;
    v.e.rgb = RGB_BUILD ? rgb : 3'b000;
    tbl.push_back(v);
  endtask

  task automatic advance(int n);
    repeat (n) @(negedge clk);
    cyc += n;
  endtask

  function automatic logic hs_at(int x, int hd, int hf, int hsw);
    return !(x >= hd + hf && x < hd + hf + hsw);
  endfunction

  // Expected outputs k clks after release, straight from the timing rules.
  function automatic obs_t model(int k, int d, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb);
    obs_t e;
    int ht, vt, n, x, y, m, xm, ym;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    n  = k / d;
    x  = n % ht;
    y  = (n / ht) % vt;
    e.p   = ((k % d) == d - 1);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.von = (x < hd) && (y < vd);
    e.lt  = e.p && (x == ht - 1);
    e.ft  = e.lt && (y == vt - 1);
    e.hs  = hs_at(x, hd, hf, hsw);
    e.vs  = hs_at(y, vd, vf, vsw);
    e.rgb = 3'b000;
    if (RGB_BUILD) begin
      if (n == 0) begin
        e.hs = 1'b1;
        e.vs = 1'b1;
      end else begin
        m  = n - 1;
        xm = m % ht;
        ym = (m / ht) % vt;
        e.hs  = hs_at(xm, hd, hf, hsw);
        e.vs  = hs_at(ym, vd, vf, vsw);
        e.rgb = ((xm < hd) && (ym < vd)) ? 3'b110 : 3'b000;
      end
    end
    return e;
  endfunction

  function automatic obs_t m0(int k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic obs_t m3(int k);
    return model(k, 3, 4, 1, 2, 1, 3, 1, 2, 1);
  endfunction
  function automatic obs_t m1(int k);
    return model(k, 1, 4, 1, 2, 1, 3, 1, 2, 1);
  endfunction

  int ft_cnt;

  initial begin
    //   k     p  x    y  hs hsr von lt rgb
    add(0,    0, 0,   0, 1, 1,  1,  0, 3'b000);
    add(1,    1, 0,   0, 1, 1,  1,  0, 3'b000);
    add(2,    0, 1,   0, 1, 1,  1,  0, 3'b110);
    add(3,    1, 1,   0, 1, 1,  1,  0, 3'b110);
    add(1279, 1, 639, 0, 1, 1,  1,  0, 3'b110);
    add(1280, 0, 640, 0, 1, 1,  0,  0, 3'b110);
    add(1281, 1, 640, 0, 1, 1,  0,  0, 3'b110);
    add(1282, 0, 641, 0, 1, 1,  0,  0, 3'b000);
    add(1311, 1, 655, 0, 1, 1,  0,  0, 3'b000);
    add(1312, 0, 656, 0, 0, 1,  0,  0, 3'b000);
    add(1314, 0, 657, 0, 0, 0,  0,  0, 3'b000);
    add(1503, 1, 751, 0, 0, 0,  0,  0, 3'b000);
    add(1504, 0, 752, 0, 1, 0,  0,  0, 3'b000);
    add(1506, 0, 753, 0, 1, 1,  0,  0, 3'b000);
    add(1599, 1, 799, 0, 1, 1,  0,  1, 3'b000);
    add(1600, 0, 0,   1, 1, 1,  1,  0, 3'b000);
    add(1602, 0, 1,   1, 1, 1,  1,  0, 3'b110);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", o0, m0(0));
    rst = 1'b0;
    cyc = 0;

    foreach (tbl[i]) begin
      advance(tbl[i].k - cyc);
      check($sformatf("tbl_k%0d", tbl[i].k), o0, tbl[i].e);
    end

    // Mid-line reset at (300,1): outputs snap to reset values immediately.
    advance(2200 - cyc);
    check("pre_rst_x300", o0, m0(2200));
    rst = 1'b1;
    #1;
    check("rst_async", o0, m0(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), o0, m0(0));
      check($sformatf("rst_hold_d3_%0d", i), o3, m3(0));
      check($sformatf("rst_hold_d1_%0d", i), o1, m1(0));
    end
    rst = 1'b0;
    cyc = 0;

    // Two full frames of the tiny timings; default instance restarts too.
    ft_cnt = 0;
    for (int k = 0; k <= 340; k++) begin
      if (k > 0) advance(1);
      check($sformatf("post_rst_k%0d", k), o0, m0(k));
      check($sformatf("d3_k%0d", k), o3, m3(k));
      check($sformatf("d1_k%0d", k), o1, m1(k));
      if (ft3) ft_cnt++;
    end
    n_total++;
    if (ft_cnt != 2)
      $display("FAIL d3_frame_ticks got=%0d expected=2", ft_cnt);
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
